// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the FIFO pointer/status controller.
package fifo_pkg;

    typedef enum logic [1:0] {S_EMPTY, S_MID, S_FULL} fifo_state_t;

    localparam int DEFAULT_ADDR_WIDTH = 2;

    // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than an address.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping circular-buffer pointer with synchronous reset and increment enable.
module fifo_ptr #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    // NOTE: non-blocking assignment so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/status controller running an external reg_file as a circular FIFO.
// Optional sticky overflow/underflow flags are built only when FIFO_CTRL_ERR_EN is defined.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int AF_THRESH  = 3,
    parameter int AE_THRESH  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wr,
    input  logic                               rd,
    input  logic                               err_clr,
    output logic                               wr_en,
    output logic [ADDR_WIDTH-1:0]              w_addr,
    output logic [ADDR_WIDTH-1:0]              r_addr,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic [count_width(ADDR_WIDTH)-1:0] count,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int CW    = count_width(ADDR_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    fifo_state_t state_q;
    logic        push_ok;
    logic        pop_ok;

    // A push into a full FIFO is allowed only when the head is popped in the same cycle.
    assign push_ok = wr & (~full | rd);
    assign pop_ok  = rd & ~empty;
    assign wr_en   = push_ok;

    fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (push_ok),
        .ptr   (w_addr)
    );

    fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop_ok),
        .ptr   (r_addr)
    );

    // Simultaneous accepted push and pop leave both count and state untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_EMPTY;
            count   <= '0;
        end else if (push_ok && !pop_ok) begin
            count   <= count + 1'b1;
            state_q <= (count == LAST) ? S_FULL : S_MID;
        end else if (pop_ok && !push_ok) begin
            count   <= count - 1'b1;
            state_q <= (count == ONE) ? S_EMPTY : S_MID;
        end
    end

    assign full         = (state_q == S_FULL);
    assign empty        = (state_q == S_EMPTY);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

`ifdef FIFO_CTRL_ERR_EN
    // Clear beats a same-cycle set so software never loses a clear to a racing error.
    always_ff @(posedge clk) begin
        if (reset || err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr && full && !rd) overflow  <= 1'b1;
            if (rd && empty)       underflow <= 1'b1;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule
